// File: rtl/rvfi_mem_pkg.sv
// rtl/rvfi_mem_pkg.sv - shared types and sizing helpers for the minrv32 memory responder
package rvfi_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  // Word-index width for a backing store of the given depth (at least 1 bit)
  function automatic int idx_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Stall-counter width able to hold max_wait (at least 1 bit)
  function automatic int wait_w(input int max_wait);
    return (max_wait > 1) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/rvfi_mem_checker.sv
// rtl/rvfi_mem_checker.sv - latches the pending request and flags any change before completion
module rvfi_mem_checker
  import rvfi_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  state_t      state,
  input  logic        pend_entry,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        protocol_err
);

  logic        lat_instr;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic        mismatch;

  always_comb begin
    mismatch = !mem_valid
            || (mem_instr != lat_instr)
            || (mem_addr  != lat_addr)
            || (mem_wdata != lat_wdata)
            || (mem_wstrb != lat_wstrb);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_instr    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_wstrb    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (pend_entry) begin
        lat_instr <= mem_instr;
        lat_addr  <= mem_addr;
        lat_wdata <= mem_wdata;
        lat_wstrb <= mem_wstrb;
      end
      // Sticky: once a request wobbles, the whole run is suspect
      if (state == PEND && mismatch) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfi_mem_responder.sv
// rtl/rvfi_mem_responder.sv - memory-side responder with bounded stalls, backing store and protocol check
module rvfi_mem_responder
  import rvfi_mem_pkg::*;
#(
  parameter int MAX_WAIT   = 3,
  parameter int FAIR       = 1,
  parameter int CONSISTENT = 1,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mem_valid,
  input  logic                          mem_instr,
  input  logic [31:0]                   mem_addr,
  input  logic [31:0]                   mem_wdata,
  input  logic [3:0]                    mem_wstrb,
  output logic                          mem_ready,
  output logic [31:0]                   mem_rdata,
  input  logic                          rand_ready,
  input  logic [31:0]                   rand_rdata,
  input  logic                          trap,
  output logic [wait_w(MAX_WAIT)-1:0]   wait_cnt,
  output logic [CNT_W-1:0]              req_count,
  output logic                          protocol_err
);

  localparam int WW = wait_w(MAX_WAIT);
  localparam int IW = idx_w(DEPTH);

  state_t          state;
  logic [31:0]     store [DEPTH];
  logic [IW-1:0]   idx;
  logic            fair_release;
  logic            pend_entry;

  assign idx = mem_addr[2 +: IW];

  always_comb begin
    fair_release = (FAIR != 0) && (wait_cnt == WW'(MAX_WAIT));
    // trap in the same cycle suppresses the handshake entirely
    mem_ready = !reset && (state != HALT) && !trap && mem_valid
             && (rand_ready || fair_release);
    pend_entry = !reset && !trap && (state == IDLE) && mem_valid && !mem_ready;
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_ready) begin
      mem_rdata = (CONSISTENT != 0) ? store[idx] : rand_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else if (trap) begin
      state <= HALT;
    end else begin
      case (state)
        IDLE:    if (mem_valid && !mem_ready) state <= PEND;
        PEND:    if (mem_ready) state <= IDLE;
        default: state <= HALT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= '0;
      req_count <= '0;
    end else if (state != HALT && !trap) begin
      if (mem_ready) begin
        wait_cnt <= '0;
        if (req_count != '1) req_count <= req_count + CNT_W'(1);
      end else if (mem_valid && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

  // mem_rdata above reads the old word, so same-cycle writes are read-before-write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (CONSISTENT != 0 && mem_ready) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (mem_wstrb[b]) store[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  rvfi_mem_checker u_checker (
    .clock        (clock),
    .reset        (reset),
    .state        (state),
    .pend_entry   (pend_entry),
    .mem_valid    (mem_valid),
    .mem_instr    (mem_instr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .protocol_err (protocol_err)
  );

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// tb/tb_rvfi_mem_responder.sv - table-driven and sequence checks for rvfi_mem_responder
module tb_rvfi_mem_responder;

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rand_ready;
  logic [31:0] rand_rdata;
  logic        trap;
  logic [1:0]  wait_cnt;
  logic [15:0] req_count;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  rvfi_mem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .mem_instr    (mem_instr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .rand_ready   (rand_ready),
    .rand_rdata   (rand_rdata),
    .trap         (trap),
    .wait_cnt     (wait_cnt),
    .req_count    (req_count),
    .protocol_err (protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rr;
    logic        e_ready;
    logic [31:0] e_rdata;
    logic [1:0]  e_wait;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic v, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic r,
                              logic er, logic [31:0] ed, logic [1:0] ew, logic [15:0] ec, logic ee);
    vec_t t;
    t.valid = v; t.addr = a; t.wdata = d; t.wstrb = s; t.rr = r;
    t.e_ready = er; t.e_rdata = ed; t.e_wait = ew; t.e_cnt = ec; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic r, input logic t, input logic rst);
    mem_valid = v; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    rand_ready = r; trap = t; reset = rst;
  endtask

  initial begin
    // rows: valid, addr, wdata, wstrb, rand_ready | ready, rdata, wait, count, err (pre-edge)
    tbl[0]  = mk(0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        2'd0, 16'd0, 0);
    tbl[1]  = mk(1, 32'h10, 32'h0,        4'h0, 0, 0, 32'h0,        2'd0, 16'd0, 0);
    tbl[2]  = mk(1, 32'h10, 32'h0,        4'h0, 0, 0, 32'h0,        2'd1, 16'd0, 0);
    tbl[3]  = mk(1, 32'h10, 32'h0,        4'h0, 0, 0, 32'h0,        2'd2, 16'd0, 0);
    tbl[4]  = mk(1, 32'h10, 32'h0,        4'h0, 0, 1, 32'h0,        2'd3, 16'd0, 0);
    tbl[5]  = mk(1, 32'h8,  32'hDEADBEEF, 4'hF, 1, 1, 32'h0,        2'd0, 16'd1, 0);
    tbl[6]  = mk(1, 32'h8,  32'h000000AA, 4'h1, 1, 1, 32'hDEADBEEF, 2'd0, 16'd2, 0);
    tbl[7]  = mk(1, 32'h8,  32'h0,        4'h0, 1, 1, 32'hDEADBEAA, 2'd0, 16'd3, 0);
    tbl[8]  = mk(1, 32'h48, 32'h0,        4'h0, 1, 1, 32'hDEADBEAA, 2'd0, 16'd4, 0);
    tbl[9]  = mk(1, 32'hC,  32'h12345678, 4'hF, 1, 1, 32'h0,        2'd0, 16'd5, 0);
    tbl[10] = mk(1, 32'hC,  32'h0,        4'h0, 1, 1, 32'h12345678, 2'd0, 16'd6, 0);
    tbl[11] = mk(0, 32'h8,  32'h0,        4'h0, 1, 0, 32'h0,        2'd0, 16'd7, 0);
    tbl[12] = mk(1, 32'h8,  32'h0,        4'h0, 0, 0, 32'h0,        2'd0, 16'd7, 0);
    tbl[13] = mk(1, 32'h8,  32'h0,        4'h0, 1, 1, 32'hDEADBEAA, 2'd1, 16'd7, 0);
    tbl[14] = mk(1, 32'h4,  32'h0,        4'h0, 0, 0, 32'h0,        2'd0, 16'd8, 0);
    tbl[15] = mk(1, 32'h8,  32'h0,        4'h0, 0, 0, 32'h0,        2'd1, 16'd8, 0);
    tbl[16] = mk(1, 32'h8,  32'h0,        4'h0, 0, 0, 32'h0,        2'd2, 16'd8, 1);
    tbl[17] = mk(1, 32'h8,  32'h0,        4'h0, 0, 1, 32'hDEADBEAA, 2'd3, 16'd8, 1);
    tbl[18] = mk(0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        2'd0, 16'd9, 1);

    mem_instr  = 1'b0;
    rand_rdata = 32'hA5A5A5A5;
    drv(0, 32'h0, 32'h0, 4'h0, 0, 0, 1);
    @(negedge clock);
    drv(1, 32'h0, 32'h0, 4'h0, 1, 0, 1);
    #1;
    chk("reset_ready", 32'(mem_ready), 32'h0);
    chk("reset_rdata", mem_rdata, 32'h0);
    @(negedge clock);

    for (int i = 0; i < 19; i++) begin
      drv(tbl[i].valid, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].rr, 0, 0);
      #1;
      chk($sformatf("row%0d ready", i), 32'(mem_ready), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d rdata", i), mem_rdata, tbl[i].e_rdata);
      chk($sformatf("row%0d wait", i), 32'(wait_cnt), 32'(tbl[i].e_wait));
      chk($sformatf("row%0d count", i), 32'(req_count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d err", i), 32'(protocol_err), 32'(tbl[i].e_err));
      @(negedge clock);
    end

    // reset in the middle of a pending request
    drv(1, 32'h0, 32'h55, 4'hF, 1, 0, 0);
    #1; chk("rst_pre_write", 32'(mem_ready), 32'h1);
    @(negedge clock);
    drv(1, 32'h4, 32'h0, 4'h0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    drv(1, 32'h4, 32'h0, 4'h0, 0, 0, 1);
    #1;
    chk("rst_mid_wait", 32'(wait_cnt), 32'd2);
    chk("rst_mid_ready", 32'(mem_ready), 32'h0);
    @(negedge clock);
    drv(0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    #1;
    chk("rst_wait", 32'(wait_cnt), 32'd0);
    chk("rst_count", 32'(req_count), 32'd0);
    chk("rst_err", 32'(protocol_err), 32'd0);
    @(negedge clock);
    drv(1, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    #1;
    chk("rst_read_ready", 32'(mem_ready), 32'h1);
    chk("rst_read_rdata", mem_rdata, 32'h0);
    @(negedge clock);

    // trap coincident with a would-be handshake
    drv(1, 32'h0, 32'hFFFFFFFF, 4'hF, 1, 1, 0);
    #1;
    chk("trap_ready", 32'(mem_ready), 32'h0);
    chk("trap_rdata", mem_rdata, 32'h0);
    @(negedge clock);
    drv(1, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    #1;
    chk("halt_ready", 32'(mem_ready), 32'h0);
    chk("halt_count", 32'(req_count), 32'd1);
    @(negedge clock);
    drv(1, 32'h4, 32'h0, 4'h0, 0, 0, 0);
    @(negedge clock);
    #1;
    chk("halt_wait", 32'(wait_cnt), 32'd0);
    chk("halt_ready2", 32'(mem_ready), 32'h0);
    @(negedge clock);
    drv(0, 32'h0, 32'h0, 4'h0, 0, 0, 1);
    @(negedge clock);
    drv(1, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    #1;
    chk("post_halt_ready", 32'(mem_ready), 32'h1);
    chk("post_halt_rdata", mem_rdata, 32'h0);
    chk("post_halt_count", 32'(req_count), 32'd0);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfi_mem_responder.md
Name: rvfi_mem_responder

Overview:
- Parametrised memory-side responder for the minrv32 native memory interface (valid/ready, addr, wdata, wstrb, rdata).
- Drives the core from free nondeterministic inputs: rand_ready and rand_rdata come from the formal tool or from a random bench driver.
- Adds three things free random drivers lack: a bounded-stall fairness guarantee of configurable depth, an optional consistent byte-addressable backing store, and a request-stability protocol checker.
- Instantiated inside formal wrappers and simulation benches, between the core and the stimulus source.

Parameters:
- MAX_WAIT, 3: maximum consecutive cycles mem_ready may stay low while a request is pending. 0 means ready on the first cycle of valid.
- FAIR, 1: 1 enforces MAX_WAIT. 0 makes readiness purely rand_ready (unbounded stalls).
- CONSISTENT, 1: 1 means reads return the backing store. 0 means reads return rand_rdata.
- DEPTH, 16: backing-store words. Must be a power of two, 2 or more.
- CNT_W, 16: width of req_count.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- mem_valid  in  1  core request valid
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 means read
- mem_ready  out  1  transfer completes this cycle
- mem_rdata  out  32  read data, meaningful only when mem_ready is high
- rand_ready  in  1  nondeterministic ready choice
- rand_rdata  in  32  nondeterministic read data
- trap  in  1  core trapped
- wait_cnt  out  $clog2(MAX_WAIT+1) (min 1)  stall cycles of the current request
- req_count  out  CNT_W  completed transfers, saturating
- protocol_err  out  1  sticky request-stability violation

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE; wait_cnt 0, req_count 0, protocol_err 0.
  - All DEPTH words cleared to 0.
  - mem_ready forced 0 and mem_rdata 0 in any cycle where reset is high.
- FSM states:
  - IDLE: no request pending.
  - PEND: request seen, not yet completed.
  - HALT: core trapped.
- Transitions:
  - IDLE→PEND when mem_valid && !mem_ready.
  - IDLE stays IDLE when mem_valid && mem_ready (single-cycle transfer).
  - PEND→IDLE when mem_ready.
  - Any state→HALT when trap is high.
  - HALT is left only via reset.
- mem_ready is combinational, with state ≠ HALT and reset low:
  - mem_valid && (rand_ready || (FAIR && wait_cnt == MAX_WAIT)).
  - MAX_WAIT=0 with FAIR=1 gives mem_ready = mem_valid.
- wait_cnt:
  - Increments each cycle where mem_valid && !mem_ready.
  - Cleared on handshake.
  - Never exceeds MAX_WAIT when FAIR=1.
  - When FAIR=0 it saturates at its maximum.
- Handshake cycle (mem_valid && mem_ready):
  - Index is mem_addr[2 +: $clog2(DEPTH)]; upper address bits alias, so addresses wrap modulo DEPTH*4.
  - CONSISTENT=1: mem_rdata is the stored word before this cycle's write (read-before-write). For each wstrb[i] set, byte i is updated at the clock edge.
  - CONSISTENT=0: mem_rdata = rand_rdata and the store is not updated.
  - mem_rdata is 0 whenever mem_ready is low.
- req_count increments on each handshake and saturates at 2^CNT_W−1.
- Protocol checker:
  - Request latched on entry to PEND.
  - While in PEND, protocol_err sets if mem_valid drops before ready, or if mem_addr, mem_wdata, mem_wstrb or mem_instr differ from the latched values.
  - protocol_err clears only on reset.
- HALT:
  - mem_ready held 0.
  - Counters and store frozen.
  - protocol_err holds its value.
- Simultaneous trap and handshake in one cycle: trap wins; no handshake, no write, no count.
- Reset mid-PEND: pending request discarded, next state IDLE, store cleared.

Decomposition:
- Package rvfi_mem_pkg holds:
  - state enum {IDLE, PEND, HALT};
  - function idx_w(DEPTH) and wait-counter width helper;
  - localparam WORD_BYTES=4.
- One sub-module, rvfi_mem_checker: latches the request on PEND entry, compares each cycle, and owns sticky protocol_err.

Test Plan:
- MAX_WAIT=3, FAIR=1, rand_ready=0, single read at 0x10 → mem_ready high on the 4th cycle of valid; wait_cnt sequence 0,1,2,3; req_count=1.
- CONSISTENT=1: write 0xDEADBEEF with wstrb=4'hF at 0x8, then write 0x000000AA with wstrb=4'h1 at 0x8, then read 0x8 → rdata 0xDEADBEAA. A read at 0x48 with DEPTH=16 aliases to the same word and returns 0xDEADBEAA.
- Read-before-write: same-cycle handshake with wstrb=4'hF, wdata=0x12345678 on word holding 0x0 → mem_rdata 0x0 that cycle; a subsequent read returns 0x12345678.
- Protocol: stall with rand_ready=0, change mem_addr 0x4→0x8 mid-PEND → protocol_err rises next cycle and stays 1 until reset.
- trap asserted in the same cycle as valid && rand_ready → mem_ready 0, no write, req_count unchanged; remains HALT until reset.
- Reset asserted in PEND with wait_cnt=2 → next cycle state IDLE, wait_cnt 0, req_count 0, a read at 0x0 returns 0.
